vram_arbiter: RTL

Single-port VRAM arbiter sitting directly downstream of the 6502 external bus interface's bus-master port. It converts the byte-wide, single-cycle-strobe bus-master accesses into 32-bit VRAM word accesses with byte lanes, or I/O register accesses. It shares the VRAM with two read-only video fetch ports using round-robin arbitration. The CPU port has absolute priority and a fixed 1-cycle read latency, because the upstream block samples `bm_rddata` exactly one cycle after its strobe.

---
 rtl/vram_pkg.sv | 20 ++
 rtl/vram_rr_arb2.sv | 27 ++
 rtl/vram_arbiter.sv | 88 ++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// vram_pkg: shared widths, region decode and byte-lane helpers for the VRAM arbiter
package vram_pkg;
    localparam int VRAM_WORD_AW = 15;
    localparam int BM_AW = 19;
    localparam int IO_AW = 6;

    typedef enum logic [1:0] {
        RSP_NONE,
        RSP_RAM,
        RSP_IO
    } rsp_src_e;

    function automatic logic is_vram(input logic [BM_AW-1:0] addr);
        return addr < 19'h20000;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        return word[8*lane +: 8];
    endfunction
endpackage

// File: rtl/vram_rr_arb2.sv
// vram_rr_arb2: two-port round-robin grant with a CPU override that blocks both ports
module vram_rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cpu_win,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic rr_r;

    // preferred port first, the other as fallback; the CPU suppresses both
    always_comb begin
        gnt = cpu_win ? 2'b00 :
              rr_r    ? (req[1] ? 2'b10 : req[0] ? 2'b01 : 2'b00) :
                        (req[0] ? 2'b01 : req[1] ? 2'b10 : 2'b00);
    end

    // after serving a port, prefer the other one; idle and CPU cycles hold the pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rr_r <= 1'b0;
        else if (gnt[0])
            rr_r <= 1'b1;
        else if (gnt[1])
            rr_r <= 1'b0;
    end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: byte-wide CPU port and two video fetch ports sharing one 32-bit VRAM
module vram_arbiter
    import vram_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [BM_AW-1:0]        bm_addr,
    input  logic [7:0]              bm_wrdata,
    input  logic                    bm_strobe,
    input  logic                    bm_write,
    output logic [7:0]              bm_rddata,
    input  logic [VRAM_WORD_AW-1:0] vf0_addr,
    input  logic [VRAM_WORD_AW-1:0] vf1_addr,
    input  logic                    vf0_req,
    input  logic                    vf1_req,
    output logic                    vf0_ack,
    output logic                    vf1_ack,
    output logic                    vf0_valid,
    output logic                    vf1_valid,
    output logic [31:0]             vf0_rddata,
    output logic [31:0]             vf1_rddata,
    output logic [VRAM_WORD_AW-1:0] ram_addr,
    output logic [31:0]             ram_wrdata,
    output logic [3:0]              ram_wrbytesel,
    output logic                    ram_write,
    input  logic [31:0]             ram_rddata,
    output logic [IO_AW-1:0]        io_addr,
    output logic [7:0]              io_wrdata,
    output logic                    io_strobe,
    output logic                    io_write,
    input  logic [7:0]              io_rddata
);
    logic       cpu_vram;
    logic       cpu_io;
    logic       cpu_wr;
    logic [1:0] gnt;
    rsp_src_e   rsp_r;
    logic [1:0] lane_r;
    logic [7:0] io_byte_r;

    assign cpu_vram = bm_strobe && is_vram(bm_addr);
    assign cpu_io   = bm_strobe && !is_vram(bm_addr);
    assign cpu_wr   = cpu_vram && bm_write;

    vram_rr_arb2 u_arb (
        .clk    (clk),
        .reset_n(reset_n),
        .cpu_win(cpu_vram),
        .req    ({vf1_req, vf0_req}),
        .gnt    (gnt)
    );

    // RAM and I/O command mux; everything idles at zero when nobody is granted
    always_comb begin
        ram_addr      = cpu_vram ? bm_addr[16:2] : gnt[0] ? vf0_addr : gnt[1] ? vf1_addr : '0;
        ram_write     = cpu_wr;
        ram_wrdata    = cpu_wr ? {4{bm_wrdata}} : '0;
        ram_wrbytesel = cpu_wr ? 4'b0001 << bm_addr[1:0] : 4'b0000;
        io_strobe     = cpu_io;
        io_write      = cpu_io && bm_write;
        io_addr       = cpu_io ? bm_addr[IO_AW-1:0] : '0;
        io_wrdata     = cpu_io ? bm_wrdata : '0;
        vf0_ack       = gnt[0];
        vf1_ack       = gnt[1];
    end

    // response pipeline: remember what the strobe/grant was so T+1 can steer the data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_r     <= RSP_NONE;
            lane_r    <= '0;
            io_byte_r <= '0;
            vf0_valid <= 1'b0;
            vf1_valid <= 1'b0;
        end else begin
            rsp_r     <= (!bm_strobe || bm_write) ? RSP_NONE : cpu_vram ? RSP_RAM : RSP_IO;
            lane_r    <= bm_addr[1:0];
            io_byte_r <= io_rddata;
            vf0_valid <= gnt[0];
            vf1_valid <= gnt[1];
        end
    end

    assign bm_rddata  = rsp_r == RSP_RAM ? lane_byte(ram_rddata, lane_r) :
                        rsp_r == RSP_IO  ? io_byte_r : 8'h00;
    assign vf0_rddata = ram_rddata;
    assign vf1_rddata = ram_rddata;
endmodule
